// File: rtl/vcopy_pkg.sv
// Shared types and helpers for the single-port memory-to-memory copy engine.
package vcopy_pkg;

   typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

   localparam int BOUNDARY_BYTES = 4096;

   // Whole words left before the next 4 KB page; addr is the in-page byte offset.
   function automatic logic [31:0] beats_to_boundary(input logic [11:0] addr, input int data_w);
      return (32'(BOUNDARY_BYTES) - {20'd0, addr}) / 32'(data_w / 8);
   endfunction

endpackage

// File: rtl/vcopy_fifo.sv
// First-word-fall-through synchronous FIFO holding words between the read and write bursts.
module vcopy_fifo #(
   parameter int DW = 32,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          pop_i,
   output logic [DW-1:0] rdata_o,
   output logic [AW:0]   count_o,
   output logic          empty_o
);
   localparam int DEPTH = 2 ** AW;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   cnt_q;
   logic          full, push_ok, pop_ok;

   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign push_ok = push_i & ~full;
   assign pop_ok  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rptr_q];
   assign count_o = cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push_ok) wptr_q <= wptr_q + 1'b1;
         if (pop_ok)  rptr_q <= rptr_q + 1'b1;
         cnt_q <= cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
      end
   end

   // Storage needs no reset: the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q] <= wdata_i;
   end

   overflow_a: assert property (@(posedge clk) disable iff (rst) !(push_i && full));

endmodule

// File: rtl/vcopy_engine.sv
// Copies WORDS words from src to dst over one shared databus port, alternating read and write
// bursts through a local FIFO; bursts are capped by max_len, FIFO space and 4 KB pages.
module vcopy_engine
   import vcopy_pkg::*;
#(
   parameter int AXI_ADDR_W = 32,
   parameter int DATA_W     = 32,
   parameter int FIFO_AW    = 4,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run,
   output logic                  done,
   input  logic [AXI_ADDR_W-1:0] src_addr,
   input  logic [AXI_ADDR_W-1:0] dst_addr,
   input  logic [CNT_W-1:0]      words,
   input  logic [7:0]            max_len,
   input  logic                  databus_ready,
   output logic                  databus_valid,
   output logic [AXI_ADDR_W-1:0] databus_addr,
   input  logic [DATA_W-1:0]     databus_rdata,
   output logic [DATA_W-1:0]     databus_wdata,
   output logic [DATA_W/8-1:0]   databus_wstrb,
   output logic [7:0]            databus_len,
   input  logic                  databus_last
);
   localparam int BPW   = DATA_W / 8;
   localparam int BSH   = $clog2(BPW);
   localparam int DEPTH = 2 ** FIFO_AW;

   state_t                state_q, state_d;
   logic [AXI_ADDR_W-1:0] src_q, src_d, dst_q, dst_d, burst_bytes;
   logic [CNT_W-1:0]      rem_q, rem_d;
   logic [7:0]            maxl_q, maxl_d, len_q, len_d;
   logic [8:0]            beat_q, beat_d;
   logic                  push, pop, fempty;
   logic [FIFO_AW:0]      fcnt, fcnt_nxt;
   logic [DATA_W-1:0]     fhead;

   function automatic logic [31:0] min4(input logic [31:0] a, b, c, d);
      logic [31:0] m;
      m = a;
      if (b < m) m = b;
      if (c < m) m = c;
      if (d < m) m = d;
      return m;
   endfunction

   function automatic logic [7:0] rd_len(input logic [11:0] a, input logic [CNT_W-1:0] n,
                                         input logic [7:0] ml, input logic [FIFO_AW:0] cnt);
      return 8'(min4(32'(n), 32'(ml) + 32'd1, 32'(DEPTH) - 32'(cnt),
                     beats_to_boundary(a, DATA_W)) - 32'd1);
   endfunction

   function automatic logic [7:0] wr_len(input logic [11:0] a, input logic [FIFO_AW:0] cnt,
                                         input logic [7:0] ml);
      return 8'(min4(32'(cnt), 32'(ml) + 32'd1, beats_to_boundary(a, DATA_W),
                     beats_to_boundary(a, DATA_W)) - 32'd1);
   endfunction

   vcopy_fifo #(.DW(DATA_W), .AW(FIFO_AW)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .wdata_i (databus_rdata),
      .pop_i   (pop),
      .rdata_o (fhead),
      .count_o (fcnt),
      .empty_o (fempty)
   );

   assign push        = (state_q == RD_BURST) & databus_ready;
   assign pop         = (state_q == WR_BURST) & databus_ready & ~fempty;
   assign fcnt_nxt    = fcnt + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
   // Addresses advance by the beats actually seen, so an early last stays consistent.
   assign burst_bytes = AXI_ADDR_W'({1'b0, beat_q} + 10'd1) << BSH;

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      rem_d   = rem_q;
      maxl_d  = maxl_q;
      len_d   = len_q;
      beat_d  = beat_q;
      case (state_q)
         IDLE: begin
            if (run && words != '0) begin
               state_d = RD_BURST;
               src_d   = src_addr;
               dst_d   = dst_addr;
               rem_d   = words;
               maxl_d  = max_len;
               beat_d  = '0;
               len_d   = rd_len(src_addr[11:0], words, max_len, '0);
            end
         end
         RD_BURST: begin
            if (databus_ready) begin
               if (rem_q != '0) rem_d = rem_q - CNT_W'(1);
               beat_d = beat_q + 9'd1;
               if (databus_last) begin
                  state_d = WR_BURST;
                  src_d   = src_q + burst_bytes;
                  beat_d  = '0;
                  len_d   = wr_len(dst_q[11:0], fcnt_nxt, maxl_q);
               end
            end
         end
         WR_BURST: begin
            if (databus_ready) begin
               beat_d = beat_q + 9'd1;
               if (databus_last) begin
                  dst_d  = dst_q + burst_bytes;
                  beat_d = '0;
                  if (rem_q != '0) begin
                     state_d = RD_BURST;
                     len_d   = rd_len(src_q[11:0], rem_q, maxl_q, fcnt_nxt);
                  end else if (fcnt_nxt != '0) begin
                     len_d = wr_len(dst_d[11:0], fcnt_nxt, maxl_q);
                  end else begin
                     state_d = IDLE;
                     len_d   = '0;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         maxl_q  <= '0;
         len_q   <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         maxl_q  <= maxl_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
      end
   end

   assign done          = (state_q == IDLE);
   assign databus_valid = (state_q != IDLE);
   assign databus_addr  = (state_q == RD_BURST) ? src_q :
                          (state_q == WR_BURST) ? dst_q : '0;
   assign databus_wstrb = {BPW{state_q == WR_BURST}};
   assign databus_wdata = (state_q == WR_BURST) ? fhead : '0;
   assign databus_len   = len_q;

endmodule
